// File: rtl/vce2_pkg.sv
// -----------------------------------------------------------------------------
// vce2_pkg
// Shared definitions for the VCE2 vector engine blocks.
//   vseq_state_e : state encoding of the vector sequencer (vce2_vseq)
//   is_mem_state : true for states that issue a memory request
// -----------------------------------------------------------------------------
package vce2_pkg;

   typedef enum logic [3:0] {
      IDLE,
      SETUP,
      RD_A,
      WAIT_A,
      RD_B,
      WAIT_B,
      EXEC,
      WR,
      DONE
   } vseq_state_e;

   function automatic logic is_mem_state(input vseq_state_e s);
      return (s == RD_A) || (s == RD_B) || (s == WR);
   endfunction

endpackage

// File: rtl/vce2_vseq.sv
// -----------------------------------------------------------------------------
// vce2_vseq
// Vector sequencer: for each of vl elements it reads operand A (rs1) and,
// optionally, operand B (rs2) from memory, presents them to an external
// combinational ALU, and writes the result back (rd). Address generation lives
// in an external AGU, steered through get_* selects and incr_o post-increment.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   start_i / start_ready_o   operation request / accepted only in IDLE
//   vl_i, two_src_i           element count and rs2-used flag, sampled on accept
//   agu_load_o / agu_ready_i  AGU counter-load pulse / AGU load complete
//   get_rs1_o/get_rs2_o/get_rd_o, incr_o
//                             AGU address select and post-increment
//   mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_wdata_o
//                             memory request/grant and read-response channel
//   op_a_o, op_b_o, op_valid_o, res_i
//                             registered operands, valid strobe, ALU result
//   busy_o, done_o            not-idle flag, one-cycle completion pulse
// -----------------------------------------------------------------------------
module vce2_vseq
   import vce2_pkg::*;
#(
   parameter int unsigned VlWidth   = 8,
   parameter int unsigned DataWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,

   input  logic                 start_i,
   output logic                 start_ready_o,
   input  logic [VlWidth-1:0]   vl_i,
   input  logic                 two_src_i,

   output logic                 agu_load_o,
   input  logic                 agu_ready_i,
   output logic                 get_rs1_o,
   output logic                 get_rs2_o,
   output logic                 get_rd_o,
   output logic                 incr_o,

   output logic                 mem_req_o,
   output logic                 mem_we_o,
   input  logic                 mem_gnt_i,
   input  logic                 mem_rvalid_i,
   input  logic [DataWidth-1:0] mem_rdata_i,
   output logic [DataWidth-1:0] mem_wdata_o,

   output logic [DataWidth-1:0] op_a_o,
   output logic [DataWidth-1:0] op_b_o,
   output logic                 op_valid_o,
   input  logic [DataWidth-1:0] res_i,

   output logic                 busy_o,
   output logic                 done_o
);

   vseq_state_e        state;
   logic [VlWidth-1:0] remaining;
   logic               two_src;
   logic               accept;
   logic               last_elem;

   assign start_ready_o = (state == IDLE);
   assign accept        = start_i && start_ready_o;
   assign agu_load_o    = accept;
   assign busy_o        = (state != IDLE);

   // remaining <= 1 also covers the defensive 0 case so the counter can never
   // wrap when the write of the final element is granted.
   assign last_elem = (remaining <= VlWidth'(1));

   // Request-side controls decode straight from the state register, so they
   // are glitch-free and stay stable for as long as a request waits for grant.
   always_comb begin
      mem_req_o  = 1'b0;
      mem_we_o   = 1'b0;
      get_rs1_o  = 1'b0;
      get_rs2_o  = 1'b0;
      get_rd_o   = 1'b0;
      op_valid_o = 1'b0;
      done_o     = 1'b0;
      unique case (state)
         RD_A: begin
            mem_req_o = 1'b1;
            get_rs1_o = 1'b1;
         end
         RD_B: begin
            mem_req_o = 1'b1;
            get_rs2_o = 1'b1;
         end
         WR: begin
            mem_req_o = 1'b1;
            mem_we_o  = 1'b1;
            get_rd_o  = 1'b1;
         end
         EXEC:    op_valid_o = 1'b1;
         DONE:    done_o     = 1'b1;
         default: ;
      endcase
   end

   assign incr_o = mem_req_o && mem_gnt_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         remaining   <= '0;
         two_src     <= 1'b0;
         op_a_o      <= '0;
         op_b_o      <= '0;
         mem_wdata_o <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  remaining <= vl_i;
                  two_src   <= two_src_i;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               if (agu_ready_i) begin
                  state <= (remaining == '0) ? DONE : RD_A;
               end
            end
            RD_A: begin
               if (mem_gnt_i) state <= WAIT_A;
            end
            WAIT_A: begin
               if (mem_rvalid_i) begin
                  op_a_o <= mem_rdata_i;
                  state  <= two_src ? RD_B : EXEC;
               end
            end
            RD_B: begin
               if (mem_gnt_i) state <= WAIT_B;
            end
            WAIT_B: begin
               if (mem_rvalid_i) begin
                  op_b_o <= mem_rdata_i;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               mem_wdata_o <= res_i;
               state       <= WR;
            end
            WR: begin
               if (mem_gnt_i) begin
                  if (remaining != '0) remaining <= remaining - VlWidth'(1);
                  state <= last_elem ? DONE : RD_A;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Structural invariants of the request interface.
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         assert ($countones({get_rs1_o, get_rs2_o, get_rd_o}) <= 1)
            else $error("vce2_vseq: more than one get_* select active");
         assert (mem_req_o == is_mem_state(state))
            else $error("vce2_vseq: mem_req_o outside a memory state");
      end
   end

endmodule

// File: tb/tb_vce2_vseq.sv
// -----------------------------------------------------------------------------
// tb_vce2_vseq
// Scoreboard bench for vce2_vseq. Directed scenarios push the expected event
// stream (grants by kind, operand strobes, writes, done) into a queue; a
// negedge monitor pops and compares whenever the DUT presents an event. A
// responder process models the AGU handshake, memory grant latency and the
// read-data channel; res_i is an adder standing in for the ALU.
// -----------------------------------------------------------------------------
module tb_vce2_vseq;

   localparam int unsigned VW = 8;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, start_ready;
   logic [VW-1:0] vl;
   logic          two_src;
   logic          agu_load, agu_ready;
   logic          rs1, rs2, rd, incr;
   logic          req, we, gnt, rvalid;
   logic [DW-1:0] rdata, wdata;
   logic [DW-1:0] op_a, op_b, res;
   logic          op_valid, busy, done;

   always #5 clk = ~clk;

   assign res = op_a + op_b;

   vce2_vseq #(.VlWidth(VW), .DataWidth(DW)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .start_ready_o(start_ready),
      .vl_i         (vl),
      .two_src_i    (two_src),
      .agu_load_o   (agu_load),
      .agu_ready_i  (agu_ready),
      .get_rs1_o    (rs1),
      .get_rs2_o    (rs2),
      .get_rd_o     (rd),
      .incr_o       (incr),
      .mem_req_o    (req),
      .mem_we_o     (we),
      .mem_gnt_i    (gnt),
      .mem_rvalid_i (rvalid),
      .mem_rdata_i  (rdata),
      .mem_wdata_o  (wdata),
      .op_a_o       (op_a),
      .op_b_o       (op_b),
      .op_valid_o   (op_valid),
      .res_i        (res),
      .busy_o       (busy),
      .done_o       (done)
   );

   typedef enum int {K_RS1, K_RS2, K_RD, K_OP, K_DONE} kind_e;
   typedef struct {
      kind_e         kind;
      logic [DW-1:0] a;   // op_a, or write data for K_RD
      logic [DW-1:0] b;   // op_b
   } exp_t;

   exp_t          sbq[$];
   logic [DW-1:0] data_a[$];
   logic [DW-1:0] data_b[$];

   int checks = 0, passes = 0;
   int cyc = 0, incr_cnt = 0, done_cnt = 0, load_cnt = 0;
   int req_cnt = 0, rs2_cnt = 0, rs2_gnt_cnt = 0;
   int load_cyc = 0, done_cyc = 0;
   int gnt_delay = 0;
   bit spur_en = 1'b0, drop_b = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic push(input kind_e k, input logic [DW-1:0] a, input logic [DW-1:0] b);
      exp_t e;
      e.kind = k;
      e.a    = a;
      e.b    = b;
      sbq.push_back(e);
   endtask

   // ---------------- monitor / scoreboard ----------------
   bit       held = 1'b0;
   logic [4:0]    held_ctl;
   logic [DW-1:0] held_wd;
   exp_t     e_m;
   int       k_m;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         chk("req_in_reset", req, 1'b0);
         held = 1'b0;
      end else begin
         if (held) begin
            chk("hold_ctl", {req, we, rs1, rs2, rd}, held_ctl);
            chk("hold_wdata", wdata, held_wd);
         end
         chk("get_onehot", ($countones({rs1, rs2, rd}) <= 1) &&
                           (req || ({rs1, rs2, rd} == 3'b000)), 1'b1);
         chk("incr_eq", incr, req && gnt);
         if (req) req_cnt++;
         if (rs2) rs2_cnt++;
         if (agu_load) begin
            load_cnt++;
            load_cyc = cyc;
         end
         if (incr) begin
            incr_cnt++;
            k_m = rd ? K_RD : (rs2 ? K_RS2 : K_RS1);
            if (rs2) rs2_gnt_cnt++;
            if (sbq.size() == 0) chk("sb_underflow_grant", k_m, 64'hFF);
            else begin
               e_m = sbq.pop_front();
               chk("grant_kind", k_m, e_m.kind);
               if (k_m == K_RD) chk("wr_data", wdata, e_m.a);
            end
         end
         if (op_valid) begin
            if (sbq.size() == 0) chk("sb_underflow_op", K_OP, 64'hFF);
            else begin
               e_m = sbq.pop_front();
               chk("op_kind", K_OP, e_m.kind);
               chk("op_a", op_a, e_m.a);
               chk("op_b", op_b, e_m.b);
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (sbq.size() == 0) chk("sb_underflow_done", K_DONE, 64'hFF);
            else begin
               e_m = sbq.pop_front();
               chk("done_kind", K_DONE, e_m.kind);
            end
         end
         held     = req && !gnt;
         held_ctl = {req, we, rs1, rs2, rd};
         held_wd  = wdata;
      end
   end

   // ---------------- AGU / memory responder ----------------
   initial begin
      bit load_p, rd_p, rd_is_b;
      int hold;
      hold = 0;
      gnt = 1'b0; rvalid = 1'b0; rdata = '0; agu_ready = 1'b0;
      forever begin
         @(negedge clk);
         load_p  = agu_load;
         rd_p    = incr && !we;
         rd_is_b = rs2;
         @(posedge clk);
         #1;
         agu_ready = load_p;
         rvalid    = 1'b0;
         rdata     = '0;
         if (rd_p && rst_n) begin
            if (rd_is_b) begin
               if (!drop_b && data_b.size() > 0) begin
                  rvalid = 1'b1;
                  rdata  = data_b.pop_front();
               end
            end else if (data_a.size() > 0) begin
               rvalid = 1'b1;
               rdata  = data_a.pop_front();
            end
         end
         if (req) begin
            gnt  = (hold >= gnt_delay);
            hold = gnt ? 0 : hold + 1;
         end else begin
            gnt  = 1'b0;
            hold = 0;
         end
         if (spur_en && req && rs1 && !gnt) begin
            rvalid = 1'b1;
            rdata  = 32'hBAD0_BAD0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic start_op(input int n, input bit two);
      @(posedge clk);
      #1;
      start   = 1'b1;
      vl      = VW'(n);
      two_src = two;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk("done_timeout", done_cnt >= target, 1'b1);
   endtask

   task automatic check_reset_vals(input string tag);
      @(negedge clk);
      chk({tag, "_start_ready"}, start_ready, 1'b1);
      chk({tag, "_ctl"}, {busy, done, op_valid, req, we, rs1, rs2, rd, incr, agu_load}, '0);
      chk({tag, "_op_a"}, op_a, '0);
      chk({tag, "_op_b"}, op_b, '0);
      chk({tag, "_wdata"}, wdata, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int b_done, b_incr, b_load, b_req, b_rs2, b_rg, n;
      rst_n = 1'b0; start = 1'b0; vl = '0; two_src = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check_reset_vals("por");

      // vl = 0: load pulse, SETUP, DONE, no memory traffic
      b_done = done_cnt; b_load = load_cnt; b_req = req_cnt;
      push(K_DONE, '0, '0);
      start_op(0, 1'b0);
      wait_done(b_done + 1, 50);
      chk("vl0_loads", load_cnt - b_load, 1);
      chk("vl0_no_req", req_cnt - b_req, 0);
      chk("vl0_latency", done_cyc - load_cyc, 2);

      // vl = 3, two sources, zero-wait grant
      data_a = '{32'h5, 32'h1, 32'h10};
      data_b = '{32'h7, 32'h2, 32'h20};
      push(K_RS1, '0, '0); push(K_RS2, '0, '0); push(K_OP, 32'h5, 32'h7);   push(K_RD, 32'hC, '0);
      push(K_RS1, '0, '0); push(K_RS2, '0, '0); push(K_OP, 32'h1, 32'h2);   push(K_RD, 32'h3, '0);
      push(K_RS1, '0, '0); push(K_RS2, '0, '0); push(K_OP, 32'h10, 32'h20); push(K_RD, 32'h30, '0);
      push(K_DONE, '0, '0);
      b_done = done_cnt; b_incr = incr_cnt;
      gnt_delay = 0;
      start_op(3, 1'b1);
      wait_done(b_done + 1, 300);
      repeat (5) @(posedge clk);
      chk("vl3_grants", incr_cnt - b_incr, 9);
      chk("vl3_done_once", done_cnt - b_done, 1);
      chk("vl3_sb_empty", sbq.size(), 0);

      // vl = 2, single source, grant delayed 4 cycles; op_b keeps 0x20
      data_a = '{32'h100, 32'h3};
      push(K_RS1, '0, '0); push(K_OP, 32'h100, 32'h20); push(K_RD, 32'h120, '0);
      push(K_RS1, '0, '0); push(K_OP, 32'h3, 32'h20);   push(K_RD, 32'h23, '0);
      push(K_DONE, '0, '0);
      b_done = done_cnt; b_rs2 = rs2_cnt;
      gnt_delay = 4;
      start_op(2, 1'b0);
      wait_done(b_done + 1, 400);
      chk("onesrc_no_rs2", rs2_cnt - b_rs2, 0);
      chk("onesrc_op_b_held", op_b, 32'h20);

      // reset asserted while waiting for operand B
      gnt_delay = 0;
      drop_b = 1'b1;
      data_a = '{32'h9};
      data_b = '{32'h4};
      push(K_RS1, '0, '0); push(K_RS2, '0, '0);
      b_rg = rs2_gnt_cnt;
      start_op(2, 1'b1);
      n = 0;
      while (rs2_gnt_cnt == b_rg && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk("waitb_reached", rs2_gnt_cnt - b_rg, 1);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      check_reset_vals("midrst");
      chk("midrst_sb_empty", sbq.size(), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      drop_b = 1'b0;
      data_a.delete();
      data_b.delete();
      check_reset_vals("postrst");

      // normal run after the abort
      data_a = '{32'h11};
      data_b = '{32'h22};
      push(K_RS1, '0, '0); push(K_RS2, '0, '0); push(K_OP, 32'h11, 32'h22); push(K_RD, 32'h33, '0);
      push(K_DONE, '0, '0);
      b_done = done_cnt;
      start_op(1, 1'b1);
      wait_done(b_done + 1, 100);

      // start held high: one operation per ready window, spurious rvalid in RD_A
      gnt_delay = 2;
      spur_en   = 1'b1;
      data_a = '{32'h40, 32'h50};
      push(K_RS1, '0, '0); push(K_OP, 32'h40, 32'h22); push(K_RD, 32'h62, '0); push(K_DONE, '0, '0);
      push(K_RS1, '0, '0); push(K_OP, 32'h50, 32'h22); push(K_RD, 32'h72, '0); push(K_DONE, '0, '0);
      b_done = done_cnt; b_load = load_cnt;
      @(posedge clk);
      #1;
      start = 1'b1; vl = VW'(1); two_src = 1'b0;
      n = 0;
      while (load_cnt < b_load + 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(b_done + 2, 200);
      repeat (10) @(posedge clk);
      chk("held_start_loads", load_cnt - b_load, 2);
      chk("held_start_dones", done_cnt - b_done, 2);
      spur_en = 1'b0;

      chk("sb_final_empty", sbq.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/vce2_vseq.md
VCE2_VSEQ -- requirements
Module: vce2_vseq

Interface
REQ-001 The block SHALL have parameter VlWidth, default 8, meaning the vector length counter width.
REQ-002 The block SHALL have parameter DataWidth, default 32, meaning the memory and operand data width.
REQ-003 The block SHALL have port clk_i  input  1  clock; rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port start_i  input  1  request to execute one vector operation.
REQ-005 The block SHALL have port start_ready_o  output  1  high only in IDLE; start accepted when start_i && start_ready_o.
REQ-006 The block SHALL have port vl_i  input  VlWidth  element count, sampled on start acceptance.
REQ-007 The block SHALL have port two_src_i  input  1  rs2 operand used, sampled on start acceptance.
REQ-008 The block SHALL have ports agu_load_o  output  1  AGU counter-load pulse; agu_ready_i  input  1  AGU address load complete.
REQ-009 The block SHALL have ports get_rs1_o, get_rs2_o, get_rd_o, incr_o  output  1 each  AGU address select and post-increment.
REQ-010 The block SHALL have ports mem_req_o  output  1; mem_we_o  output  1; mem_gnt_i  input  1; mem_rvalid_i  input  1.
REQ-011 The block SHALL have ports mem_rdata_i  input  DataWidth; mem_wdata_o  output  DataWidth.
REQ-012 The block SHALL have ports op_a_o, op_b_o  output  DataWidth  registered operands; op_valid_o  output  1  operands valid; res_i  input  DataWidth  combinational ALU result.
REQ-013 The block SHALL have ports busy_o  output  1  state != IDLE; done_o  output  1  one-cycle completion pulse.

Function
REQ-014 States SHALL be IDLE, SETUP, RD_A, WAIT_A, RD_B, WAIT_B, EXEC, WR, DONE.
REQ-015 IDLE: on start acceptance, the block SHALL assert agu_load_o for exactly that cycle, latch vl_i into remaining and two_src_i into a flag, and go to SETUP.
REQ-016 SETUP SHALL wait for agu_ready_i; on agu_ready_i it SHALL go to DONE if remaining==0, else to RD_A.
REQ-017 RD_A SHALL drive mem_req_o=1, mem_we_o=0, get_rs1_o=1; on mem_gnt_i it SHALL assert incr_o in the same cycle and go to WAIT_A.
REQ-018 WAIT_A SHALL capture mem_rdata_i into op_a_o on mem_rvalid_i, then go to RD_B if the two_src flag is set, else to EXEC.
REQ-019 RD_B/WAIT_B SHALL mirror RD_A/WAIT_A using get_rs2_o and op_b_o; when two_src is clear, op_b_o SHALL hold its previous value.
REQ-020 EXEC SHALL assert op_valid_o for one cycle, register res_i into mem_wdata_o, and go to WR.
REQ-021 WR SHALL drive mem_req_o=1, mem_we_o=1, get_rd_o=1; on mem_gnt_i it SHALL assert incr_o and decrement remaining, then go to DONE if remaining became 0, else to RD_A.
REQ-022 DONE SHALL assert done_o for one cycle, then go to IDLE.
REQ-023 At most one get_* output SHALL be high in any cycle; all get_* outputs SHALL be 0 outside RD_A/RD_B/WR.
REQ-024 incr_o SHALL equal mem_req_o && mem_gnt_i.
REQ-025 mem_req_o SHALL stay high with stable mem_we_o, get_* and mem_wdata_o until mem_gnt_i.
REQ-026 mem_gnt_i and mem_rvalid_i SHALL be ignored in states where they are not expected.
REQ-027 start_i while busy SHALL be ignored with no effect.
REQ-028 vl_i SHALL support up to 2^VlWidth-1 elements; remaining SHALL never wrap below 0.

Reset
REQ-029 On reset the block SHALL enter IDLE, clear remaining, the two_src flag, op_a_o, op_b_o and mem_wdata_o, and drive all 1-bit outputs to 0 except start_ready_o=1.
REQ-030 Reset asserted mid-operation SHALL abort immediately with no further mem_req_o.

Structure
REQ-031 The state enum type SHALL reside in shared package vce2_pkg.
REQ-032 The block SHALL contain no sub-module; the element counter SHALL be inline, and the AGU SHALL be instantiated by the parent.

Verification
REQ-033 With vl=3, two_src=1, zero-wait gnt and rvalid 1 cycle later, the bench SHALL check 9 grants, 9 incr_o pulses in order rs1,rs2,rd x3, and done_o once.
REQ-034 With vl=0, the bench SHALL check agu_load_o pulse -> SETUP -> DONE, and no mem_req_o.
REQ-035 With vl=2, two_src=0 and gnt delayed 4 cycles, the bench SHALL check that mem_req_o, mem_we_o and get_* are held stable, that get_rs2_o never asserts, and that op_b_o is unchanged.
REQ-036 With rdata A=0x5, B=0x7 and res_i=A+B, the bench SHALL check op_a_o=0x5, op_b_o=0x7, and a write with mem_wdata_o=0xC.
REQ-037 With rst_ni pulsed in WAIT_B, the bench SHALL check IDLE, all outputs at reset values, and a subsequent start runs normally.
REQ-038 With start_i held through an operation, the bench SHALL check exactly one operation per start_ready_o window, and that spurious rvalid in RD_A is ignored.
